// File: rtl/spi_pkg.sv
// Shared SPI link definitions, used by both ends of the link (spi_master and spi_slave).
// Contents:
//   spi_slave_state_t  responder FSM state encoding
//   SPI_CPOL/SPI_CPHA  link clock mode (mode 0)
//   SPI_DATA_W         bits per SPI byte
//   SPI_IDLE_BYTE      byte sent when the responder has nothing queued
package spi_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_slave_state_t;

  localparam int             SPI_CPOL      = 0;
  localparam int             SPI_CPHA      = 0;
  localparam int             SPI_DATA_W    = 8;
  localparam logic [7:0]     SPI_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_sync.sv
// Synchronizer for one asynchronous SPI pin with edge detection.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset; every flop loads RST_VAL
//   din    asynchronous pin
//   level  synchronized level (last synchronizer stage)
//   rise   one-cycle flag: level went 0 -> 1
//   fall   one-cycle flag: level went 1 -> 0
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   level_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p  <= {SYNC_STAGES{RST_VAL}};
      level_p <= RST_VAL;
    end else begin
      sync_p  <= {sync_p[SYNC_STAGES-2:0], din};
      level_p <= sync_p[SYNC_STAGES-1];
    end
  end

  // Edges compare the newest synchronized sample with the one before it.
  assign level = sync_p[SYNC_STAGES-1];
  assign rise  = level & ~level_p;
  assign fall  = ~level & level_p;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first. The SPI pins are
// oversampled in the clk domain; one byte is returned on miso for every byte
// received on mosi, and frames may run several bytes while cs stays low.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   cs           chip select from master, active low (asynchronous)
//   sclk, mosi   SPI clock and master data (asynchronous)
//   miso         responder data out
//   tx_data      next byte to send; tx_valid qualifies it
//   tx_ready     holding register empty
//   rx_data      last complete received byte, held until the next strobe
//   rx_valid     one-cycle strobe: rx_data updated
//   tx_underrun  one-cycle pulse: byte started with nothing queued
//   frame_abort  one-cycle pulse: cs rose in the middle of a byte
//   busy         FSM is in SHIFT
module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = DATA_W'(SPI_IDLE_BYTE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  // Edge flags are meaningless until the synchronizers hold real pin samples
  // rather than their reset value; this many cycles flush them.
  localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_slave_state_t  state;
  logic [SW-1:0]     settle_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              byte_done;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              armed;
  logic              byte_start;
  logic              hold_wr;

  // A cs that was already low at reset release only produces its fall edge
  // while settling, so it is ignored until cs rises and falls again.
  assign armed = (settle_cnt == SETTLE);

  // cs_rise wins over a coincident sclk fall, so the closing fall of the
  // last byte in a frame does not start a new byte.
  assign byte_start = ((state == IDLE) && cs_fall && armed) ||
                      ((state == SHIFT) && !cs_rise && sclk_fall && byte_done);

  assign hold_wr  = tx_valid && !hold_full;
  assign tx_ready = !hold_full;
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      bit_cnt     <= '0;
      byte_done   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      if (!armed) begin
        settle_cnt <= settle_cnt + SW'(1);
      end

      // Holding register: a write that coincides with a byte start on an
      // empty register lands here; that byte start still sends IDLE_BYTE.
      if (byte_start && hold_full) begin
        hold_full <= 1'b0;
      end else if (hold_wr) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end

      case (state)
        IDLE: begin
          miso      <= 1'b0;
          bit_cnt   <= '0;
          byte_done <= 1'b0;
          if (cs_fall && armed) begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            miso      <= 1'b0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            // Partial byte is dropped; only a mid-byte rise is an abort.
            if (bit_cnt != '0) begin
              frame_abort <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            if (bit_cnt == BW'(DATA_W - 1)) begin
              bit_cnt   <= '0;
              byte_done <= 1'b1;
              rx_data   <= {rx_shift[DATA_W-2:0], mosi_s};
              rx_valid  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (sclk_fall) begin
            if (byte_done) begin
              byte_done <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              miso     <= tx_shift[DATA_W-2];
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Byte start: load the next byte and present its MSB on miso.
      if (byte_start) begin
        if (hold_full) begin
          tx_shift <= hold_data;
          miso     <= hold_data[DATA_W-1];
        end else begin
          tx_shift    <= IDLE_BYTE;
          miso        <= IDLE_BYTE[DATA_W-1];
          tx_underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: models a mode-0 master (sclk 200 ns period
// against a 50 MHz clk) and checks bytes, strobes and pulses.
module tb_spi_slave;

  localparam int HALF = 5;  // clk cycles per sclk half period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       frame_abort;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         un_cnt = 0;
  int         ab_cnt = 0;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_abort(frame_abort), .busy(busy)
  );

  always #10 clk = ~clk;

  // Record every strobe and pulse so short events inside transfers are seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_underrun) un_cnt++;
      if (frame_abort) ab_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_fall", tx_ready, 0);
  endtask

  // Shifts nbits MSB first; miso is sampled as sclk rises. With last set,
  // cs rises together with the final sclk fall.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit last,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(HALF);
      sclk = 1'b1;
      mi[7-i] = miso;
      wait_clk(HALF);
      sclk = 1'b0;
      if (last && i == nbits - 1) cs = 1'b1;
    end
  endtask

  logic [7:0] m1, m2, m3;
  int rx_base, un_base, ab_base;

  initial begin
    // Reset state
    wait_clk(3);
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_clk(10);

    // Single byte
    rx_base = rx_q.size(); un_base = un_cnt; ab_base = ab_cnt;
    write_tx(8'hA5);
    cs = 1'b0;
    wait_clk(2 * HALF);
    check("single_busy", busy, 1);
    check("single_tx_ready", tx_ready, 1);
    xfer(8'h3C, 8, 1'b1, m1);
    wait_clk(10);
    check("single_miso", m1, 8'hA5);
    check("single_rx_cnt", rx_q.size() - rx_base, 1);
    check("single_rx_data", rx_q[rx_base], 8'h3C);
    check("single_rx_hold", rx_data, 8'h3C);
    check("single_underrun", un_cnt - un_base, 0);
    check("single_abort", ab_cnt - ab_base, 0);
    check("single_idle_busy", busy, 0);
    check("single_idle_miso", miso, 0);

    // Three-byte frame
    rx_base = rx_q.size(); un_base = un_cnt;
    write_tx(8'h11);
    cs = 1'b0;
    wait_clk(2 * HALF);
    write_tx(8'h22);
    xfer(8'h01, 8, 1'b0, m1);
    xfer(8'h02, 8, 1'b0, m2);
    xfer(8'h03, 8, 1'b1, m3);
    wait_clk(10);
    check("three_miso1", m1, 8'h11);
    check("three_miso2", m2, 8'h22);
    check("three_miso3", m3, 8'h00);
    check("three_underrun", un_cnt - un_base, 1);
    check("three_rx_cnt", rx_q.size() - rx_base, 3);
    check("three_rx1", rx_q[rx_base], 8'h01);
    check("three_rx2", rx_q[rx_base+1], 8'h02);
    check("three_rx3", rx_q[rx_base+2], 8'h03);

    // Abort after 5 rises; queued byte survives the abort
    rx_base = rx_q.size(); ab_base = ab_cnt;
    cs = 1'b0;
    wait_clk(2 * HALF);
    write_tx(8'hC3);
    xfer(8'hAA, 5, 1'b1, m1);
    wait_clk(10);
    check("abort_pulse", ab_cnt - ab_base, 1);
    check("abort_no_rx", rx_q.size() - rx_base, 0);
    check("abort_busy", busy, 0);
    check("abort_hold_kept", tx_ready, 0);
    cs = 1'b0;
    wait_clk(2 * HALF);
    xfer(8'hF0, 8, 1'b1, m1);
    wait_clk(10);
    check("abort_next_miso", m1, 8'hC3);
    check("abort_next_rx_cnt", rx_q.size() - rx_base, 1);
    check("abort_next_rx", rx_data, 8'hF0);
    check("abort_no_more", ab_cnt - ab_base, 1);

    // Write collision with the cs_fall edge
    rx_base = rx_q.size(); un_base = un_cnt;
    cs = 1'b0;
    wait_clk(2);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    check("coll_busy", busy, 1);
    check("coll_underrun", tx_underrun, 1);
    check("coll_tx_ready", tx_ready, 0);
    wait_clk(2 * HALF);
    xfer(8'h5B, 8, 1'b0, m1);
    xfer(8'hC6, 8, 1'b1, m2);
    wait_clk(10);
    check("coll_byte1", m1, 8'h00);
    check("coll_byte2", m2, 8'h77);
    check("coll_underrun_cnt", un_cnt - un_base, 1);
    check("coll_rx2", rx_data, 8'hC6);

    // Reset mid-frame
    cs = 1'b0;
    wait_clk(2 * HALF);
    xfer(8'hE7, 3, 1'b0, m1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("rmid_miso", miso, 0);
    check("rmid_busy", busy, 0);
    check("rmid_tx_ready", tx_ready, 1);
    check("rmid_rx_data", rx_data, 8'h00);
    check("rmid_rx_valid", rx_valid, 0);
    rx_base = rx_q.size();
    xfer(8'hFF, 8, 1'b0, m1);
    wait_clk(10);
    check("rmid_no_rx", rx_q.size() - rx_base, 0);
    check("rmid_still_idle", busy, 0);
    check("rmid_miso_idle", m1, 8'h00);
    cs = 1'b1;
    wait_clk(2 * HALF);
    cs = 1'b0;
    wait_clk(2 * HALF);
    xfer(8'h96, 8, 1'b1, m1);
    wait_clk(10);
    check("rmid_recover_rx", rx_data, 8'h96);
    check("rmid_recover_cnt", rx_q.size() - rx_base, 1);

    // Idle: sclk toggling with cs high
    rx_base = rx_q.size(); un_base = un_cnt; ab_base = ab_cnt;
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      wait_clk(HALF);
      sclk = 1'b1;
      check("idle_miso_hi", miso, 0);
      wait_clk(HALF);
      sclk = 1'b0;
      check("idle_busy", busy, 0);
    end
    wait_clk(10);
    check("idle_no_rx", rx_q.size() - rx_base, 0);
    check("idle_no_underrun", un_cnt - un_base, 0);
    check("idle_no_abort", ab_cnt - ab_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
